// File: rtl/apb_soc_ctrl_mc.sv
// APB SoC control block: FC boot configuration, lockable pad mux/config registers,
// per-cluster boot addresses and per-cluster power sequencing with a done interrupt.
module apb_soc_ctrl_mc #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NB_PADS        = 64,
  parameter int unsigned NB_CLUSTERS    = 2,
  parameter int unsigned NB_CORES       = 8,
  parameter logic [31:0] BOOT_ADDR_RST  = 32'h1A00_0080,
  parameter int unsigned PWR_DLY        = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               fc_bootaddr_o,
  output logic                      fc_fetchen_o,
  output logic [2*NB_PADS-1:0]      pad_mux_o,
  output logic [6*NB_PADS-1:0]      pad_cfg_o,
  output logic [NB_CLUSTERS-1:0]    cluster_pow_o,
  output logic [NB_CLUSTERS-1:0]    cluster_rstn_o,
  output logic [NB_CLUSTERS-1:0]    cluster_fetch_enable_o,
  output logic [64*NB_CLUSTERS-1:0] cluster_boot_addr_o,
  output logic                      cluster_irq_o
);

  localparam int unsigned NB_MUX_REGS = (NB_PADS + 15) / 16;
  localparam int unsigned NB_CFG_REGS = (NB_PADS + 3) / 4;
  localparam logic [9:0]  W_INFO      = 10'd0;
  localparam logic [9:0]  W_BOOT      = 10'd1;
  localparam logic [9:0]  W_FETCH     = 10'd2;
  localparam logic [9:0]  W_LOCK      = 10'd3;
  localparam logic [9:0]  W_MUX_BASE  = 10'd4;
  localparam logic [9:0]  W_MUX_END   = 10'(4 + NB_MUX_REGS);
  localparam logic [9:0]  W_CFG_BASE  = 10'd64;
  localparam logic [9:0]  W_CFG_END   = 10'(64 + NB_CFG_REGS);
  localparam logic [9:0]  W_CL_BASE   = 10'd128;
  localparam logic [9:0]  W_CL_END    = 10'(128 + 4 * NB_CLUSTERS);
  localparam logic [7:0]  DLY_LOAD    = 8'(PWR_DLY - 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_RUN    = 3'd2,
    ST_STOP   = 3'd3,
    ST_PWR_DN = 3'd4
  } cl_state_e;

  logic [9:0]             widx_s;
  logic [2:0]             cl_idx_s;
  logic [1:0]             cl_reg_s;
  logic                   is_mux_s, is_cfg_s, is_cl_s;
  logic                   hit_s, ro_s, lockable_s, access_s, err_s, wr_s;
  logic [31:0]            rdata_s;
  logic                   lock_r, fetchen_r, irq_r;
  logic [31:0]            bootaddr_r;
  logic [2*NB_PADS-1:0]   pad_mux_r;
  logic [6*NB_PADS-1:0]   pad_cfg_r;
  logic [NB_CLUSTERS-1:0] req_r, done_r, done_nxt_s, set_done_s, clr_done_s;
  logic [NB_CLUSTERS-1:0] pow_nxt_s, rstn_nxt_s, fetch_nxt_s, pow_r, rstn_r, fetch_r;
  cl_state_e              state_r     [NB_CLUSTERS];
  cl_state_e              state_nxt_s [NB_CLUSTERS];
  logic [7:0]             cnt_r       [NB_CLUSTERS];
  logic [7:0]             cnt_nxt_s   [NB_CLUSTERS];
  logic [31:0]            boot_lo_r   [NB_CLUSTERS];
  logic [31:0]            boot_hi_r   [NB_CLUSTERS];
  logic                   sel_req_s, sel_done_s;
  logic [2:0]             sel_state_s;
  logic [31:0]            sel_lo_s, sel_hi_s;

  // The cluster window starts on a 32-word boundary, so the word index bits split directly.
  assign widx_s   = PADDR[11:2];
  assign cl_idx_s = widx_s[4:2];
  assign cl_reg_s = widx_s[1:0];
  assign is_mux_s = (widx_s >= W_MUX_BASE) && (widx_s < W_MUX_END);
  assign is_cfg_s = (widx_s >= W_CFG_BASE) && (widx_s < W_CFG_END);
  assign is_cl_s  = (widx_s >= W_CL_BASE) && (widx_s < W_CL_END);

  // Select the addressed cluster's fields for readback
  always_comb begin
    sel_req_s   = 1'b0;
    sel_done_s  = 1'b0;
    sel_state_s = 3'd0;
    sel_lo_s    = 32'h0;
    sel_hi_s    = 32'h0;
    for (int c = 0; c < NB_CLUSTERS; c++) begin
      sel_req_s   |= (cl_idx_s == 3'(c)) & req_r[c];
      sel_done_s  |= (cl_idx_s == 3'(c)) & done_r[c];
      sel_state_s |= (cl_idx_s == 3'(c)) ? state_r[c] : 3'd0;
      sel_lo_s    |= (cl_idx_s == 3'(c)) ? boot_lo_r[c] : 32'h0;
      sel_hi_s    |= (cl_idx_s == 3'(c)) ? boot_hi_r[c] : 32'h0;
    end
  end

  // Address decode and read data mux
  always_comb begin
    hit_s      = 1'b0;
    ro_s       = 1'b0;
    lockable_s = 1'b0;
    rdata_s    = 32'h0;
    if (widx_s == W_INFO) begin
      hit_s   = 1'b1;
      ro_s    = 1'b1;
      rdata_s = {16'(NB_CORES), 16'(NB_CLUSTERS)};
    end else if (widx_s == W_BOOT) begin
      hit_s      = 1'b1;
      lockable_s = 1'b1;
      rdata_s    = bootaddr_r;
    end else if (widx_s == W_FETCH) begin
      hit_s   = 1'b1;
      rdata_s = {31'h0, fetchen_r};
    end else if (widx_s == W_LOCK) begin
      hit_s   = 1'b1;
      rdata_s = {31'h0, lock_r};
    end else if (is_mux_s) begin
      hit_s      = 1'b1;
      lockable_s = 1'b1;
      for (int p = 0; p < NB_PADS; p++) begin
        rdata_s[2*(p%16) +: 2] |= (widx_s == W_MUX_BASE + 10'(p/16)) ? pad_mux_r[2*p +: 2] : 2'b00;
      end
    end else if (is_cfg_s) begin
      hit_s      = 1'b1;
      lockable_s = 1'b1;
      for (int p = 0; p < NB_PADS; p++) begin
        rdata_s[8*(p%4) +: 6] |= (widx_s == W_CFG_BASE + 10'(p/4)) ? pad_cfg_r[6*p +: 6] : 6'h00;
      end
    end else if (is_cl_s) begin
      hit_s = 1'b1;
      case (cl_reg_s)
        2'd0:    rdata_s = {31'h0, sel_req_s};
        2'd1:    rdata_s = {23'h0, sel_done_s, 5'h0, sel_state_s};
        2'd2:    rdata_s = sel_lo_s;
        2'd3:    rdata_s = sel_hi_s;
        default: rdata_s = 32'h0;
      endcase
    end else begin
      hit_s = 1'b0;
    end
  end

  assign access_s = PSEL & PENABLE;
  assign err_s    = access_s & (~hit_s | (PWRITE & ro_s) | (PWRITE & lockable_s & lock_r));
  assign wr_s     = access_s & PWRITE & ~err_s;
  assign PSLVERR  = err_s;
  assign PRDATA   = err_s ? 32'h0 : rdata_s;
  assign PREADY   = 1'b1;

  // FC boot configuration, lock and pad registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lock_r     <= 1'b0;
      fetchen_r  <= 1'b1;
      bootaddr_r <= BOOT_ADDR_RST;
      pad_mux_r  <= {(2*NB_PADS){1'b0}};
      pad_cfg_r  <= {NB_PADS{6'h3F}};
    end else if (wr_s) begin
      if (widx_s == W_BOOT) bootaddr_r <= PWDATA;
      if (widx_s == W_FETCH) fetchen_r <= PWDATA[0];
      if ((widx_s == W_LOCK) && PWDATA[0]) lock_r <= 1'b1;
      for (int p = 0; p < NB_PADS; p++) begin
        if (widx_s == W_MUX_BASE + 10'(p/16)) pad_mux_r[2*p +: 2] <= PWDATA[2*(p%16) +: 2];
        if (widx_s == W_CFG_BASE + 10'(p/4)) pad_cfg_r[6*p +: 6] <= PWDATA[8*(p%4) +: 6];
      end
    end
  end

  // W1C requests on STATUS; a same-cycle sequence completion wins over the clear
  always_comb begin
    clr_done_s = {NB_CLUSTERS{1'b0}};
    for (int c = 0; c < NB_CLUSTERS; c++) begin
      clr_done_s[c] = wr_s & is_cl_s & (cl_idx_s == 3'(c)) & (cl_reg_s == 2'd1) & PWDATA[8];
    end
    done_nxt_s = set_done_s | (done_r & ~clr_done_s);
  end

  // Cluster request, boot address, done flag and interrupt registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      req_r  <= {NB_CLUSTERS{1'b0}};
      done_r <= {NB_CLUSTERS{1'b0}};
      irq_r  <= 1'b0;
      for (int c = 0; c < NB_CLUSTERS; c++) begin
        boot_lo_r[c] <= 32'h0;
        boot_hi_r[c] <= 32'h0;
      end
    end else begin
      done_r <= done_nxt_s;
      irq_r  <= |done_nxt_s;
      for (int c = 0; c < NB_CLUSTERS; c++) begin
        if (wr_s && is_cl_s && (cl_idx_s == 3'(c))) begin
          case (cl_reg_s)
            2'd0:    req_r[c]     <= PWDATA[0];
            2'd2:    boot_lo_r[c] <= PWDATA;
            2'd3:    boot_hi_r[c] <= PWDATA;
            default: begin end
          endcase
        end
      end
    end
  end

  // Cluster FSM state and delay counter registers
  always_ff @(posedge HCLK) begin
    for (int c = 0; c < NB_CLUSTERS; c++) begin
      if (HRESET) begin
        state_r[c] <= ST_OFF;
        cnt_r[c]   <= 8'h00;
      end else begin
        state_r[c] <= state_nxt_s[c];
        cnt_r[c]   <= cnt_nxt_s[c];
      end
    end
  end

  // Cluster FSM next state; req is only looked at in OFF and RUN
  always_comb begin
    set_done_s = {NB_CLUSTERS{1'b0}};
    for (int c = 0; c < NB_CLUSTERS; c++) begin
      state_nxt_s[c] = state_r[c];
      cnt_nxt_s[c]   = cnt_r[c];
      case (state_r[c])
        ST_OFF: begin
          if (req_r[c]) begin
            state_nxt_s[c] = ST_PWR_UP;
            cnt_nxt_s[c]   = DLY_LOAD;
          end else begin
            state_nxt_s[c] = ST_OFF;
          end
        end
        ST_PWR_UP: begin
          if (cnt_r[c] == 8'h00) begin
            state_nxt_s[c] = ST_RUN;
            set_done_s[c]  = 1'b1;
          end else begin
            cnt_nxt_s[c] = cnt_r[c] - 8'h01;
          end
        end
        ST_RUN: begin
          if (!req_r[c]) begin
            state_nxt_s[c] = ST_STOP;
          end else begin
            state_nxt_s[c] = ST_RUN;
          end
        end
        ST_STOP: begin
          state_nxt_s[c] = ST_PWR_DN;
          cnt_nxt_s[c]   = DLY_LOAD;
        end
        ST_PWR_DN: begin
          if (cnt_r[c] == 8'h00) begin
            state_nxt_s[c] = ST_OFF;
            set_done_s[c]  = 1'b1;
          end else begin
            cnt_nxt_s[c] = cnt_r[c] - 8'h01;
          end
        end
        default: begin
          state_nxt_s[c] = ST_OFF;
          cnt_nxt_s[c]   = 8'h00;
        end
      endcase
    end
  end

  // Cluster output levels derived from the upcoming state
  always_comb begin
    pow_nxt_s   = {NB_CLUSTERS{1'b0}};
    rstn_nxt_s  = {NB_CLUSTERS{1'b0}};
    fetch_nxt_s = {NB_CLUSTERS{1'b0}};
    for (int c = 0; c < NB_CLUSTERS; c++) begin
      case (state_nxt_s[c])
        ST_PWR_UP: pow_nxt_s[c] = 1'b1;
        ST_RUN: begin
          pow_nxt_s[c]   = 1'b1;
          rstn_nxt_s[c]  = 1'b1;
          fetch_nxt_s[c] = 1'b1;
        end
        ST_STOP:   pow_nxt_s[c] = 1'b1;
        default:   pow_nxt_s[c] = 1'b0;
      endcase
    end
  end

  // Cluster output registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pow_r   <= {NB_CLUSTERS{1'b0}};
      rstn_r  <= {NB_CLUSTERS{1'b0}};
      fetch_r <= {NB_CLUSTERS{1'b0}};
    end else begin
      pow_r   <= pow_nxt_s;
      rstn_r  <= rstn_nxt_s;
      fetch_r <= fetch_nxt_s;
    end
  end

  assign fc_bootaddr_o          = bootaddr_r;
  assign fc_fetchen_o           = fetchen_r;
  assign pad_mux_o              = pad_mux_r;
  assign pad_cfg_o              = pad_cfg_r;
  assign cluster_pow_o          = pow_r;
  assign cluster_rstn_o         = rstn_r;
  assign cluster_fetch_enable_o = fetch_r;
  assign cluster_irq_o          = irq_r;

  for (genvar c = 0; c < NB_CLUSTERS; c++) begin : g_boot
    assign cluster_boot_addr_o[64*c +: 64] = {boot_hi_r[c], boot_lo_r[c]};
  end

endmodule
